// File: rtl/nibble_mac_datapath.sv
// Nibble multiply-accumulate datapath for a four-phase sequential 8x8 multiplier.
// Each phase multiplies one nibble pair, weights it by the phase, and loads or accumulates it.
module nibble_mac_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in1,
  input  logic [3:0]  in2,
  input  logic [1:0]  state,
  output logic [7:0]  mult_out,
  output logic [15:0] app_out,
  output logic [15:0] out,
  output logic        done
);

  logic [3:0]  shift_amt;
  logic [15:0] acc_reg;
  logic [15:0] acc_next;
  logic        done_reg;

  always_comb begin
    mult_out = {4'b0000, in1} * {4'b0000, in2};
  end

  // Cross phases (loA*hiB and hiA*loB) share the same nibble weight.
  always_comb begin
    shift_amt = 4'd0;
    case (state)
      2'b00:   shift_amt = 4'd0;
      2'b01:   shift_amt = 4'd4;
      2'b10:   shift_amt = 4'd4;
      2'b11:   shift_amt = 4'd8;
      default: shift_amt = 4'd0;
    endcase
    app_out = {8'h00, mult_out} << shift_amt;
  end

  // Phase 00 starts a new product; anything else wraps modulo 2^16.
  always_comb begin
    acc_next = (state == 2'b00) ? app_out : acc_reg + app_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg  <= 16'h0000;
      done_reg <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      done_reg <= (state == 2'b11);
    end
  end

  assign out  = acc_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_nibble_mac_datapath.sv
// Scoreboard bench for nibble_mac_datapath: a driver pushes expected responses from an
// arithmetic reference model; two monitors pop and compare combinational and registered outputs.
module tb_nibble_mac_datapath;

  logic        clk;
  logic        rst;
  logic [3:0]  in1;
  logic [3:0]  in2;
  logic [1:0]  state;
  logic [7:0]  mult_out;
  logic [15:0] app_out;
  logic [15:0] out;
  logic        done;

  nibble_mac_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .state    (state),
    .mult_out (mult_out),
    .app_out  (app_out),
    .out      (out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
    int         exp_mult;
    int         exp_app;
    int         exp_out;
    bit         exp_done;
    int         spec_out;
  } txn_t;

  txn_t comb_q[$];
  txn_t reg_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int model_acc = 0;

  function automatic int phase_weight(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 16;
      2'd2:    return 16;
      default: return 256;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp, input txn_t t);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: rst=%0d in1=%h in2=%h state=%0d got 0x%0h expected 0x%0h",
               name, t.r, t.a, t.b, t.s, got, exp);
    end
  endtask

  // One clock of stimulus; the reference model is plain integer arithmetic.
  task automatic step(input bit r, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s, input int spec = -1);
    txn_t t;
    @(negedge clk);
    rst = r; in1 = a; in2 = b; state = s;
    t.r = r; t.a = a; t.b = b; t.s = s;
    t.exp_mult = int'(a) * int'(b);
    t.exp_app  = t.exp_mult * phase_weight(s);
    if (r)            model_acc = 0;
    else if (s == 0)  model_acc = t.exp_app;
    else              model_acc = (model_acc + t.exp_app) % 65536;
    t.exp_out  = model_acc;
    t.exp_done = !r && (s == 2'd3);
    t.spec_out = spec;
    comb_q.push_back(t);
    reg_q.push_back(t);
    $display("[TB] txn rst=%0d in1=%h in2=%h state=%0d -> exp out=0x%04h done=%0d",
             r, a, b, s, t.exp_out, t.exp_done);
  endtask

  task automatic product(input logic [7:0] a, input logic [7:0] b, input int spec = -1);
    step(1'b0, a[3:0], b[3:0], 2'd0);
    step(1'b0, a[3:0], b[7:4], 2'd1);
    step(1'b0, a[7:4], b[3:0], 2'd2);
    step(1'b0, a[7:4], b[7:4], 2'd3, spec);
  endtask

  // Combinational monitor: inputs change at negedge, sampled 2 time units later.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        t = comb_q.pop_front();
        check("mult_out", int'(mult_out), t.exp_mult, t);
        check("app_out", int'(app_out), t.exp_app, t);
      end
    end
  end

  // Registered monitor: sampled just after the edge that consumed the transaction.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        t = reg_q.pop_front();
        check("out", int'(out), t.exp_out, t);
        check("done", int'(done), int'(t.exp_done), t);
        if (t.spec_out >= 0) check("spec_out", int'(out), t.spec_out, t);
      end
    end
  end

  initial begin
    txn_t dummy;
    logic [7:0] ra, rb;
    rst = 1'b1; in1 = 4'h0; in2 = 4'h0; state = 2'd0;

    // Reset with arbitrary inputs holds out at zero.
    step(1'b1, 4'h0, 4'h0, 2'd0, 0);
    step(1'b1, 4'hF, 4'hF, 2'd3, 0);

    // Full combinational sweep (also exercises wrapping accumulation).
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          step(1'b0, 4'(a), 4'(b), 2'(s));

    // 0xFF * 0xFF with per-phase checks.
    step(1'b0, 4'hF, 4'hF, 2'd0, 225);
    step(1'b0, 4'hF, 4'hF, 2'd1, 3825);
    step(1'b0, 4'hF, 4'hF, 2'd2, 7425);
    step(1'b0, 4'hF, 4'hF, 2'd3, 16'hFE01);

    // 0x12 * 0x34, then a reload.
    step(1'b0, 4'h2, 4'h4, 2'd0, 8);
    step(1'b0, 4'h2, 4'h3, 2'd1, 104);
    step(1'b0, 4'h1, 4'h4, 2'd2, 168);
    step(1'b0, 4'h1, 4'h3, 2'd3, 936);
    step(1'b0, 4'h5, 4'h5, 2'd0, 25);

    // Wrap on repeated phase 11.
    step(1'b1, 4'h3, 4'h7, 2'd1, 0);
    step(1'b0, 4'hF, 4'hF, 2'd3, 16'hE100);
    step(1'b0, 4'hF, 4'hF, 2'd3, 16'hC200);

    // Reset mid-sequence, then a partial phase adds onto zero.
    step(1'b0, 4'hF, 4'hF, 2'd0, 225);
    step(1'b0, 4'hF, 4'hF, 2'd1, 3825);
    step(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)), 0);
    step(1'b0, 4'hF, 4'hF, 2'd2, 16'h0E10);

    // Random legal products: final out must be the full 8x8 product.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      product(ra, rb, int'(ra) * int'(rb));
    end

    // Random phase soup including occasional resets.
    for (int i = 0; i < 60; i++)
      step(($urandom_range(9) == 0), 4'($urandom_range(15)), 4'($urandom_range(15)),
           2'($urandom_range(3)));

    // Bounded drain of the scoreboard.
    repeat (3) @(negedge clk);
    #3;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      dummy.r = 0; dummy.a = 0; dummy.b = 0; dummy.s = 0;
      check("drain", comb_q.size() + reg_q.size(), 0, dummy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
